// File: rtl/vdp_cpu_port.sv
// Host-side CPU port of a TMS9918-style VDP: VRAM write port, read-ahead
// buffer with prefetch sequencing, control-register file and vblank status/irq.
//
// state      | meaning
// IDLE       | accepting host strobes, cpu_ready high
// PF_ISSUE   | vram_raddr presented to the memory
// PF_CAPTURE | memory data valid, loaded into the read-ahead buffer
module vdp_cpu_port #(
    parameter int AW   = 14,
    parameter int NREG = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic              cpu_mode,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ready,
    input  logic              vsync_in,
    output logic              irq,
    output logic              vram_we,
    output logic [AW-1:0]     vram_waddr,
    output logic [7:0]        vram_wdata,
    output logic [AW-1:0]     vram_raddr,
    input  logic [7:0]        vram_rdata,
    output logic [8*NREG-1:0] vdp_regs
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PF_ISSUE   = 2'd1,
        PF_CAPTURE = 2'd2
    } state_t;

    state_t        state_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_inc;
    logic [AW-1:0] addr_set;
    logic [7:0]    latch_q;
    logic [7:0]    buf_q;
    logic          first_q;
    logic          status_q;
    logic [7:0]    regs_q [NREG];
    logic          wr_acc;
    logic          rd_acc;

    assign addr_inc  = addr_q + AW'(1);
    assign addr_set  = AW'({cpu_wdata[5:0], latch_q});
    assign cpu_ready = (state_q == IDLE);
    assign wr_acc    = cpu_wr && (state_q == IDLE);
    assign rd_acc    = cpu_rd && !cpu_wr && (state_q == IDLE);

    for (genvar i = 0; i < NREG; i++) begin : g_regs
        assign vdp_regs[8*i +: 8] = regs_q[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            latch_q    <= '0;
            buf_q      <= '0;
            first_q    <= 1'b0;
            status_q   <= 1'b0;
            cpu_rdata  <= '0;
            irq        <= 1'b0;
            vram_we    <= 1'b0;
            vram_waddr <= '0;
            vram_wdata <= '0;
            vram_raddr <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            vram_we <= 1'b0;
            irq     <= status_q & regs_q[1][5];
            if (vsync_in) status_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (wr_acc) begin
                        if (cpu_mode) begin
                            if (!first_q) begin
                                latch_q <= cpu_wdata;
                                first_q <= 1'b1;
                            end else begin
                                first_q <= 1'b0;
                                if (cpu_wdata[7]) begin
                                    regs_q[cpu_wdata[2:0]] <= latch_q;
                                end else begin
                                    addr_q <= addr_set;
                                    // read-address set primes the buffer
                                    if (!cpu_wdata[6]) begin
                                        vram_raddr <= addr_set;
                                        state_q    <= PF_ISSUE;
                                    end
                                end
                            end
                        end else begin
                            vram_we    <= 1'b1;
                            vram_waddr <= addr_q;
                            vram_wdata <= cpu_wdata;
                            buf_q      <= cpu_wdata;
                            addr_q     <= addr_inc;
                            first_q    <= 1'b0;
                        end
                    end else if (rd_acc) begin
                        first_q <= 1'b0;
                        if (cpu_mode) begin
                            cpu_rdata <= {status_q, 7'b0};
                            // a vblank landing on the read must not be lost
                            if (!vsync_in) status_q <= 1'b0;
                        end else begin
                            cpu_rdata  <= buf_q;
                            addr_q     <= addr_inc;
                            vram_raddr <= addr_inc;
                            state_q    <= PF_ISSUE;
                        end
                    end
                end
                PF_ISSUE: begin
                    state_q <= PF_CAPTURE;
                end
                PF_CAPTURE: begin
                    buf_q   <= vram_rdata;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Scoreboard bench for vdp_cpu_port: stimulus pushes expected VRAM writes,
// read results and prefetch addresses; a monitor pops and compares them.
module tb_vdp_cpu_port;

    localparam int AW   = 14;
    localparam int NREG = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cpu_wr = 1'b0;
    logic              cpu_rd = 1'b0;
    logic              cpu_mode = 1'b0;
    logic [7:0]        cpu_wdata = '0;
    logic [7:0]        cpu_rdata;
    logic              cpu_ready;
    logic              vsync_in = 1'b0;
    logic              irq;
    logic              vram_we;
    logic [AW-1:0]     vram_waddr;
    logic [7:0]        vram_wdata;
    logic [AW-1:0]     vram_raddr;
    logic [7:0]        vram_rdata = '0;
    logic [8*NREG-1:0] vdp_regs;

    vdp_cpu_port #(.AW(AW), .NREG(NREG)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_wr     (cpu_wr),
        .cpu_rd     (cpu_rd),
        .cpu_mode   (cpu_mode),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .vsync_in   (vsync_in),
        .irq        (irq),
        .vram_we    (vram_we),
        .vram_waddr (vram_waddr),
        .vram_wdata (vram_wdata),
        .vram_raddr (vram_raddr),
        .vram_rdata (vram_rdata),
        .vdp_regs   (vdp_regs)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (vram_we) mem[vram_waddr] <= vram_wdata;
        vram_rdata <= mem[vram_raddr];
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [AW+7:0] exp_wr_q [$];
    logic [7:0]    exp_rd_q [$];
    logic [AW-1:0] exp_pf_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // monitor: samples 1 time unit after each rising edge
    logic rdy_prev = 1'b1;
    logic we_prev  = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            rdy_prev = 1'b1;
            we_prev  = 1'b0;
        end else begin
            if (vram_we) begin
                check("we_not_back_to_back", we_prev, 1'b0);
                if (exp_wr_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL vram_write actual=%0h/%0h required=none", vram_waddr, vram_wdata);
                end else begin
                    check("vram_write", {vram_waddr, vram_wdata}, exp_wr_q.pop_front());
                end
            end
            if (cpu_rd && !cpu_wr && rdy_prev) begin
                if (exp_rd_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL cpu_read actual=%0h required=none", cpu_rdata);
                end else begin
                    check("cpu_rdata", cpu_rdata, exp_rd_q.pop_front());
                end
            end
            if (rdy_prev && !cpu_ready) begin
                if (exp_pf_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL prefetch actual=%0h required=none", vram_raddr);
                end else begin
                    check("vram_raddr", vram_raddr, exp_pf_q.pop_front());
                end
            end
            rdy_prev = cpu_ready;
            we_prev  = vram_we;
        end
    end

    task automatic strobe(input logic wr, input logic rd, input logic mode,
                          input logic [7:0] d, input logic vs, input bit wait_rdy);
        int n;
        @(negedge clk);
        if (wait_rdy) begin
            n = 0;
            while (!cpu_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!cpu_ready) begin
                n_cmp++; n_err++;
                $display("FAIL ready_timeout actual=0 required=1");
            end
        end
        cpu_wr = wr; cpu_rd = rd; cpu_mode = mode; cpu_wdata = d; vsync_in = vs;
        @(negedge clk);
        cpu_wr = 1'b0; cpu_rd = 1'b0; vsync_in = 1'b0;
    endtask

    task automatic cwr(input logic [7:0] d); strobe(1'b1, 1'b0, 1'b1, d, 1'b0, 1'b1); endtask
    task automatic dwr(input logic [7:0] d); strobe(1'b1, 1'b0, 1'b0, d, 1'b0, 1'b1); endtask
    task automatic crd();                    strobe(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1); endtask
    task automatic drd();                    strobe(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1); endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        mem[14'h0100] = 8'h11;
        mem[14'h0101] = 8'h22;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", cpu_ready, 1'b1);
        check("rst_rdata", cpu_rdata, 8'h00);
        check("rst_irq", irq, 1'b0);
        check("rst_regs", vdp_regs, 64'h0);
        check("rst_we", vram_we, 1'b0);
        check("rst_raddr", vram_raddr, 14'h0000);

        // register writes leave the address alone
        cwr(8'h07); cwr(8'h87);
        check("reg7", vdp_regs[63:56], 8'h07);
        cwr(8'hE0); cwr(8'h81);
        check("reg1", vdp_regs[15:8], 8'hE0);
        exp_wr_q.push_back({14'h0000, 8'h5A});
        dwr(8'h5A);

        // write address set and auto-increment
        cwr(8'h00); cwr(8'h78);
        exp_wr_q.push_back({14'h3800, 8'hAA}); dwr(8'hAA);
        exp_wr_q.push_back({14'h3801, 8'hBB}); dwr(8'hBB);
        exp_wr_q.push_back({14'h3802, 8'hCC}); dwr(8'hCC);

        // read address set with prefetch, then read-ahead reads
        exp_pf_q.push_back(14'h0100);
        cwr(8'h00); cwr(8'h01);
        n = 0;
        while (!cpu_ready && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("ready_low_cycles", n, 2);
        exp_rd_q.push_back(8'h11); exp_pf_q.push_back(14'h0101); drd();
        exp_rd_q.push_back(8'h22); exp_pf_q.push_back(14'h0102); drd();

        // address wrap
        cwr(8'hFF); cwr(8'h7F);
        exp_wr_q.push_back({14'h3FFF, 8'h55}); dwr(8'h55);
        exp_wr_q.push_back({14'h0000, 8'h66}); dwr(8'h66);

        // vblank status and irq
        cwr(8'h20); cwr(8'h81);
        @(negedge clk); vsync_in = 1'b1;
        @(negedge clk); vsync_in = 1'b0;
        check("irq_not_yet", irq, 1'b0);
        @(negedge clk);
        check("irq_set", irq, 1'b1);
        exp_rd_q.push_back(8'h80); crd();
        check("irq_hold_after_read", irq, 1'b1);
        @(negedge clk);
        check("irq_cleared", irq, 1'b0);
        exp_rd_q.push_back(8'h00); crd();
        exp_rd_q.push_back(8'h00); strobe(1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
        exp_rd_q.push_back(8'h80); crd();

        // single control byte then data read resets the byte pairing
        cwr(8'h34);
        exp_rd_q.push_back(8'h66); exp_pf_q.push_back(14'h0002); drd();
        cwr(8'h00); cwr(8'h40);
        exp_wr_q.push_back({14'h0000, 8'h77}); dwr(8'h77);
        check("regs_after_pairing", vdp_regs, 64'h0700_0000_0000_2000);

        // strobe during prefetch is ignored
        exp_rd_q.push_back(8'h77); exp_pf_q.push_back(14'h0002); drd();
        strobe(1'b1, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0);
        exp_wr_q.push_back({14'h0002, 8'hAB}); dwr(8'hAB);

        // reset in mid-prefetch
        exp_rd_q.push_back(8'hAB); exp_pf_q.push_back(14'h0004); drd();
        check("pf_in_progress", cpu_ready, 1'b0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready", cpu_ready, 1'b1);
        check("mid_rst_rdata", cpu_rdata, 8'h00);
        check("mid_rst_raddr", vram_raddr, 14'h0000);
        check("mid_rst_waddr", {vram_we, vram_waddr, vram_wdata}, 23'h0);
        check("mid_rst_regs", vdp_regs, 64'h0);
        check("mid_rst_irq", irq, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_rd_q.push_back(8'h00); exp_pf_q.push_back(14'h0001); drd();

        repeat (5) @(negedge clk);
        check("wr_q_drained", exp_wr_q.size(), 0);
        check("rd_q_drained", exp_rd_q.size(), 0);
        check("pf_q_drained", exp_pf_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vdp_cpu_port.md
Name: vdp_cpu_port

Overview:
- Host-side (writer) end of the VDP video-RAM and register interface, in the style of the TMS9918 CPU port.
- Accepts byte-wide host strobes on a data port and a control port.
- Produces the VRAM write port, the VRAM read-ahead path and the VDP control-register file. The display-side table reader consumes these.
- Sits between the host bus and the VRAM block memories, in the pixel-clock domain.

Parameters:
- AW, 14: VRAM address width. Addresses wrap modulo 2^AW.
- NREG, 8: number of control registers. Index is the low 3 bits of the register-write byte.

Ports:
- clk  in  1  pixel clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_wr  in  1  one-cycle write strobe, already synchronous to clk.
- cpu_rd  in  1  one-cycle read strobe, already synchronous to clk.
- cpu_mode  in  1  port select: 0 = data (VRAM), 1 = control.
- cpu_wdata  in  8  write byte, sampled with cpu_wr.
- cpu_rdata  out  8  read result, registered.
- cpu_ready  out  1  high when a new strobe will be accepted.
- vsync_in  in  1  one-cycle pulse at the start of vertical blank.
- irq  out  1  interrupt request.
- vram_we  out  1  one-cycle VRAM write enable.
- vram_waddr  out  AW  VRAM write address.
- vram_wdata  out  8  VRAM write data.
- vram_raddr  out  AW  VRAM read address; the memory returns data 1 cycle later.
- vram_rdata  in  8  VRAM read data.
- vdp_regs  out  8*NREG  register file; register n is bits [8n+7:8n].

Behaviour:
- Reset (async assert, sync release) clears to 0: addr, latch byte, first_flag, read-ahead buffer, cpu_rdata, vdp_regs, status flag, vram_we, vram_waddr, vram_wdata, vram_raddr, irq. FSM goes to IDLE; cpu_ready=1.
- FSM states: IDLE, PF_ISSUE, PF_CAPTURE. cpu_ready=1 only in IDLE. Strobes outside IDLE are ignored: no state change, no write. cpu_wr and cpu_rd asserted together: cpu_wr wins, cpu_rd is ignored.
- Control write, first byte (first_flag=0): latch byte <= cpu_wdata; first_flag <= 1.
- Control write, second byte (first_flag=1), always first_flag <= 0, then one of:
  - bit7=1: register write, regs[cpu_wdata[2:0]] <= latch.
  - bit7=0, bit6=1: set write address, addr <= {cpu_wdata[5:0], latch}, truncated/zero-extended to AW.
  - bit7=0, bit6=0: set read address as above, then IDLE -> PF_ISSUE (read-ahead prefetch).
- Data write:
  - vram_we=1 on the next cycle, with vram_waddr=addr and vram_wdata=cpu_wdata.
  - Read-ahead buffer <= cpu_wdata.
  - addr <= addr+1, wrapping 2^AW-1 -> 0.
  - first_flag <= 0.
  - cpu_ready stays 1.
- Data read:
  - cpu_rdata <= buffer on the next cycle.
  - addr <= addr+1 (wrapping); first_flag <= 0.
  - Go to PF_ISSUE.
- Prefetch: PF_ISSUE drives vram_raddr=addr, then PF_CAPTURE. PF_CAPTURE captures buffer <= vram_rdata, then IDLE. cpu_ready is low for exactly 2 cycles.
- Control read:
  - cpu_rdata <= {status_flag, 7'b0}.
  - status_flag <= 0 and first_flag <= 0.
  - If vsync_in arrives in the same cycle, the flag stays set and the value read shows the old flag.
- vsync_in sets status_flag in any state.
- irq is registered: irq = status_flag & regs[1][5]. It drops the cycle after the flag is cleared or the enable bit is cleared.
- vram_we is never high for 2 consecutive cycles.
- cpu_rdata holds its value until the next accepted read.
- A reset in mid-prefetch returns to IDLE immediately; the buffer is cleared.

Test Plan:
1. Control writes 0x07, then 0x87 → vdp_regs[63:56]=0x07. Control writes 0xE0, then 0x81 → vdp_regs[15:8]=0xE0. addr is unchanged.
2. Control writes 0x00, then 0x78 → write address 0x3800. Data writes 0xAA, 0xBB → vram_we pulses with (0x3800,0xAA) and (0x3801,0xBB); addr=0x3802.
3. Preload VRAM[0x0100]=0x11 and VRAM[0x0101]=0x22. Control writes 0x00, then 0x01 → cpu_ready low 2 cycles. Data reads → 0x11, then 0x22. The bench checks the vram_raddr sequence 0x0100, 0x0101, 0x0102.
4. Write address 0x3FFF, data write 0x55 → write lands at 0x3FFF, addr wraps to 0x0000. Next data write goes to 0x0000.
5. regs[1]=0x20, pulse vsync_in → irq=1 one cycle later. Control read returns 0x80 → irq=0 next cycle. A second control read returns 0x00.
6. Control writes a single byte 0x34, then a data read → first_flag cleared. Control writes 0x00, 0x40 → write address 0x0000, not a register write. A cpu_wr issued while cpu_ready=0 produces no vram_we. Asserting reset_n=0 mid-prefetch → all outputs 0 and cpu_ready=1.
